// File: rtl/demux_route_ctrl.sv
// rtl/demux_route_ctrl.sv - single-beat 1:NCH demux route controller with timeout drop
module demux_route_ctrl #(
  parameter int DW      = 8,
  parameter int NCH     = 4,
  parameter int SELW    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [SELW-1:0] in_sel,
  output logic [NCH-1:0]  out_valid,
  input  logic [NCH-1:0]  out_ready,
  output logic [DW-1:0]   out_data,
  output logic            drop,
  output logic [7:0]      err_cnt
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0]   TO_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SELW-1:0] RR_LAST = SELW'(NCH - 1);
  localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [SELW-1:0] dest_q, dest_d;
  logic [SELW-1:0] rr_q, rr_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            drop_q, drop_d;
  logic [7:0]      err_q, err_d;
  logic            accept;
  logic [7:0]      err_inc;

  // Saturating increment used by both discard paths.
  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  // One-hot offer of the held beat to its destination while sending.
  always_comb begin
    out_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      out_valid[i] = (state_q == SEND) && (dest_q == SELW'(i));
    end
  end

  assign accept   = |(out_valid & out_ready);
  assign in_ready = (state_q == IDLE) && !rst;
  assign out_data = data_q;
  assign drop     = drop_q;
  assign err_cnt  = err_q;

  // Next-state: capture and route in IDLE, wait for accept or timeout in SEND.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    rr_d    = rr_q;
    wait_d  = wait_q;
    drop_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          if (mode) begin
            dest_d  = rr_q;
            rr_d    = (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
            state_d = SEND;
            wait_d  = '0;
          end else if ({1'b0, in_sel} >= NCH_W) begin
            // Unroutable address: swallow the beat and report it.
            drop_d = 1'b1;
            err_d  = err_inc;
          end else begin
            dest_d  = in_sel;
            state_d = SEND;
            wait_d  = '0;
          end
        end
      end
      SEND: begin
        if (accept) begin
          state_d = IDLE;
        end else if ((TIMEOUT > 0) && (wait_q == TO_LAST)) begin
          state_d = IDLE;
          drop_d  = 1'b1;
          err_d   = err_inc;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any held beat uncounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      dest_q  <= '0;
      rr_q    <= '0;
      wait_q  <= '0;
      drop_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      rr_q    <= rr_d;
      wait_q  <= wait_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// tb/tb_demux_route_ctrl.sv - scoreboard bench for demux_route_ctrl
module tb_demux_route_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic [3:0] out_ready = '0;
  logic       in_ready, drop;
  logic [3:0] out_valid;
  logic [7:0] out_data, err_cnt;

  logic       b_mode = 1'b0, b_in_valid = 1'b0;
  logic [7:0] b_in_data = '0;
  logic [1:0] b_in_sel = '0;
  logic [2:0] b_out_ready = '0;
  logic       b_in_ready, b_drop;
  logic [2:0] b_out_valid;
  logic [7:0] b_out_data, b_err_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] oh;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  demux_route_ctrl #(.DW(8), .NCH(4), .SELW(2), .TIMEOUT(16)) u0 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop(drop), .err_cnt(err_cnt)
  );

  demux_route_ctrl #(.DW(8), .NCH(3), .SELW(2), .TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .drop(b_drop), .err_cnt(b_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a transfer will complete at the next edge, pop and compare.
  always @(negedge clk) begin
    if (!rst && ((out_valid & out_ready) != 4'b0)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_transfer", {28'b0, out_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_out_valid", {28'b0, out_valid}, {28'b0, e.oh});
        check("sb_out_data", {24'b0, out_data}, {24'b0, e.data});
      end
    end
  end

  task automatic send_beat(input logic m, input logic [1:0] s, input logic [7:0] d,
                           input logic [3:0] exp_oh);
    in_valid = 1'b1; mode = m; in_sel = s; in_data = d;
    #1 check("in_ready_idle", {31'b0, in_ready}, 32'h1);
    sb.push_back('{exp_oh, d});
    @(posedge clk); #1;
    in_valid = 1'b0; in_sel = s ^ 2'b01; mode = ~m;
    check("send_onehot", {28'b0, out_valid}, {28'b0, exp_oh});
    check("send_in_ready", {31'b0, in_ready}, 32'h0);
    check("send_data", {24'b0, out_data}, {24'b0, d});
    @(posedge clk); #1;
    check("idle_after_accept", {28'b0, out_valid}, 32'h0);
  endtask

  task automatic wait_drop(input logic [3:0] exp_oh, input int exp_n, input logic [7:0] exp_err);
    int n = 0;
    while (out_valid == exp_oh && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("offer_cycles", n, exp_n);
    check("drop_pulse", {31'b0, drop}, 32'h1);
    check("err_after_drop", {24'b0, err_cnt}, {24'b0, exp_err});
    check("in_ready_after_drop", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    check("drop_one_cycle", {31'b0, drop}, 32'h0);
  endtask

  initial begin
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    check("rst_out_valid", {28'b0, out_valid}, 32'h0);
    check("rst_out_data", {24'b0, out_data}, 32'h0);
    check("rst_drop", {31'b0, drop}, 32'h0);
    check("rst_err", {24'b0, err_cnt}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Addressed routing.
    out_ready = 4'b1111;
    send_beat(1'b0, 2'd2, 8'hA5, 4'b0100);
    send_beat(1'b0, 2'd0, 8'h5A, 4'b0001);
    send_beat(1'b0, 2'd1, 8'hC3, 4'b0010);
    send_beat(1'b0, 2'd3, 8'h3C, 4'b1000);

    // Round-robin wrap, in_sel ignored.
    send_beat(1'b1, 2'd3, 8'h10, 4'b0001);
    send_beat(1'b1, 2'd3, 8'h11, 4'b0010);
    send_beat(1'b1, 2'd3, 8'h12, 4'b0100);
    send_beat(1'b1, 2'd3, 8'h13, 4'b1000);
    send_beat(1'b1, 2'd3, 8'h14, 4'b0001);
    send_beat(1'b1, 2'd3, 8'h15, 4'b0010);

    // Backpressure to timeout.
    out_ready = 4'b0000;
    in_valid = 1'b1; mode = 1'b0; in_sel = 2'd1; in_data = 8'h77;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_drop(4'b0010, 16, 8'd1);

    // Late accept on the final wait cycle wins over timeout.
    in_valid = 1'b1; mode = 1'b0; in_sel = 2'd1; in_data = 8'h88;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    check("late_still_offered", {28'b0, out_valid}, 32'h2);
    sb.push_back('{4'b0010, 8'h88});
    out_ready = 4'b0010;
    @(posedge clk); #1;
    out_ready = 4'b0000;
    check("late_idle", {28'b0, out_valid}, 32'h0);
    check("late_no_drop", {31'b0, drop}, 32'h0);
    check("late_err_same", {24'b0, err_cnt}, 32'h1);

    // Ready on another channel is ignored.
    out_ready = 4'b1000;
    in_valid = 1'b1; mode = 1'b0; in_sel = 2'd1; in_data = 8'h99;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_drop(4'b0010, 16, 8'd2);
    out_ready = 4'b0000;

    // Reset in the middle of SEND.
    in_valid = 1'b1; mode = 1'b0; in_sel = 2'd2; in_data = 8'h42;
    @(posedge clk); #1; in_valid = 1'b0;
    check("pre_rst_valid", {28'b0, out_valid}, 32'h4);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", {28'b0, out_valid}, 32'h0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'h0);
    check("midrst_err", {24'b0, err_cnt}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("post_rst_drop", {31'b0, drop}, 32'h0);
    out_ready = 4'b1111;
    send_beat(1'b1, 2'd2, 8'hE1, 4'b0001);

    // Invalid select on a 3-channel instance, then saturation.
    b_in_valid = 1'b1; b_mode = 1'b0; b_in_sel = 2'd3; b_in_data = 8'h66;
    #1 check("b_in_ready", {31'b0, b_in_ready}, 32'h1);
    @(posedge clk); #1;
    check("b_no_offer", {29'b0, b_out_valid}, 32'h0);
    check("b_drop", {31'b0, b_drop}, 32'h1);
    check("b_err1", {24'b0, b_err_cnt}, 32'h1);
    check("b_still_ready", {31'b0, b_in_ready}, 32'h1);
    repeat (259) @(posedge clk);
    #1 b_in_valid = 1'b0;
    check("b_err_sat", {24'b0, b_err_cnt}, 32'hFF);
    @(posedge clk); #1;
    check("b_drop_end", {31'b0, b_drop}, 32'h0);
    check("b_err_hold", {24'b0, b_err_cnt}, 32'hFF);

    check("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_route_ctrl.md
Name: demux_route_ctrl

Overview:
- Controller that sequences a single input data stream onto NCH output channels of a 1:NCH demultiplexer using valid/ready handshakes.
- Destination comes from either an address supplied with each beat or an internal round-robin pointer.
- Holds one beat at a time.
- Discards a beat if its destination does not accept within TIMEOUT cycles, and counts the discard as an error.
- Sits between a single producer and a bank of per-channel consumers in the demux datapath.

Parameters:
- DW, 8, data width.
- NCH, 4, number of output channels (2..2^SELW).
- SELW, 2, width of the destination select.
- TIMEOUT, 16, cycles a held beat may wait for out_ready before being dropped; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = addressed (use in_sel), 1 = round-robin.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  controller can accept a beat.
- in_data  in  DW  beat payload.
- in_sel  in  SELW  destination channel in addressed mode.
- out_valid  out  NCH  one-hot; bit i means the beat is offered to channel i.
- out_ready  in  NCH  per-channel accept.
- out_data  out  DW  held payload, shared by all channels.
- drop  out  1  one-cycle pulse when a beat is discarded.
- err_cnt  out  8  saturating count of discarded beats.

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE; any held beat is lost and is not counted.
  - out_valid = 0, out_data = 0, drop = 0, err_cnt = 0.
  - Round-robin pointer rr = 0, wait counter = 0.
  - in_ready = 0 while rst is high.
- States: IDLE, SEND.
- IDLE:
  - in_ready = 1 combinationally.
  - On a clock edge with in_valid=1, the beat is captured into out_data.
  - Destination select: addressed mode uses in_sel; round-robin mode uses rr.
  - mode and in_sel are sampled only at capture. A later change does not affect the held beat.
  - Round-robin mode only: rr advances by 1 at capture and wraps NCH-1 -> 0. rr never changes in addressed mode.
  - Addressed mode with in_sel >= NCH: the beat is consumed (handshake completes), not offered, and the next cycle pulses drop=1 with err_cnt+1. State stays IDLE.
  - Otherwise the next state is SEND with the wait counter cleared to 0.
- SEND:
  - in_ready = 0.
  - out_valid has exactly one bit set, bit dest, from the cycle after capture until the transfer ends.
  - out_data is stable throughout SEND.
  - Accept: out_ready[dest]=1 at an edge completes the transfer; next cycle is IDLE with out_valid = 0.
  - out_ready on other channels is ignored.
  - Wait counting: each cycle without accept increments the wait counter.
  - Timeout: with TIMEOUT>0, if the counter equals TIMEOUT-1 and out_ready[dest]=0 at the edge:
    - the beat is dropped; next cycle is IDLE with out_valid = 0;
    - drop pulses for exactly 1 cycle;
    - err_cnt increments, saturating at 255.
  - A beat therefore remains offered for TIMEOUT cycles.
  - If accept and timeout coincide at the same edge, accept wins: no drop.
- Throughput and latency:
  - Maximum rate is 1 beat per 2 cycles.
  - Capture-to-out_valid latency is 1 cycle.
  - drop is registered and never coincides with out_valid for the same beat.
- err_cnt only changes on a drop.

Test Plan:
- Reset mid-SEND: assert rst while out_valid=4'b0100 -> out_valid=0, in_ready=0 immediately; after release, in_ready=1, err_cnt=0, rr=0.
- Addressed routing: mode=0, send in_data=8'hA5 with in_sel=2, out_ready=4'b1111 -> out_valid=4'b0100 one cycle after capture, out_data=8'hA5, back to IDLE next cycle; repeat for sel 0,1,3.
- Round-robin wrap: mode=1, 6 beats 8'h10..8'h15, all ready -> destinations 0,1,2,3,0,1; in_sel ignored.
- Backpressure and timeout: TIMEOUT=16, sel=1, out_ready=0 -> out_valid=4'b0010 for exactly 16 cycles, then drop=1 for 1 cycle, err_cnt=1, in_ready=1.
- Late accept and coincidence: out_ready[1] raised at the 16th wait cycle -> accepted, drop=0, err_cnt unchanged. Raising out_ready[3] only while dest=1 -> no transfer, timeout occurs.
- Saturation and invalid select: NCH=3, in_sel=3 -> handshake completes, no out_valid, drop pulse, err_cnt+1. Force 260 drops -> err_cnt holds at 255.
